ex_md: RTL and testbench
========================

Name: ex_md

Overview:
- Parametrised next-generation execute stage.
- Keeps the single-cycle ALU path, pipeline register and memory-request decode of the current EX stage.
- Adds an iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU) that holds the pipeline via a busy signal.
- Adds alignment checking on memory requests.
- Sits between ID and MEM; upstream stages must OR o_busy into their stall.

Parameters:
- WORD_W, 32: datapath width; multiple of BITS_PER_CYCLE, ≥ 8.
- ADDR_W, 32: address width (≤ WORD_W); o_mem_req_addr = low ADDR_W bits of result.
- BITS_PER_CYCLE, 1: quotient/multiplier bits retired per RUN cycle (1, 2 or 4); N = WORD_W/BITS_PER_CYCLE iterations.

Ports:
- clk  in  1  clock.
- clr  in  1  synchronous active-high reset.
- stall  in  1  downstream stall; hold the pipeline register.
- i_pc  in  ADDR_W  instruction PC.
- i_instr  in  `INSTR_W  instruction word.
- i_alu_op  in  `ALU_OP_W  ALU operation.
- i_alu_data_a  in  WORD_W  operand A.
- i_alu_data_b  in  WORD_W  operand B.
- i_imm  in  WORD_W  immediate; also store data.
- i_md_op  in  3  0=NONE, 1=MUL (low word), 2=MULHU (high word), 3=DIVU, 4=REMU; others treated as NONE.
- i_mem_op  in  `MEM_OP_W  memory op code.
- i_dest_src  in  `DEST_SRC_W  writeback source.
- i_dest_reg  in  `REG_IDX_W  writeback register.
- o_pc  out  ADDR_W  registered PC.
- o_instr  out  `INSTR_W  registered instruction.
- o_dest_src  out  `DEST_SRC_W  registered dest src; `DEST_SRC_NONE while o_busy.
- o_dest_reg  out  `REG_IDX_W  registered dest reg.
- o_result  out  WORD_W  MD result when the registered md_op ≠ NONE, else ALU eval.
- o_busy  out  1  MD unit iterating; upstream must stall.
- o_mem_req_addr  out  ADDR_W  ALU eval.
- o_mem_req_wr_data  out  WORD_W  registered imm.
- o_mem_req_wr_en  out  1  write request.
- o_mem_req_count  out  `MEM_COUNT_W  access size.
- o_misalign  out  1  misaligned memory request flagged.

Behaviour:
- Interface: one clock, clk; reset clr is synchronous, active-high.
- Pipeline register:
  - clr: pc/instr/operands/imm = 0, alu_op = `ALU_ADD, md_op = NONE, mem_op = `MEM_OP_NOP, dest_src = `DEST_SRC_NONE, dest_reg = 0.
  - Loads when stall==0 and o_busy==0; otherwise holds.
- Reset outputs:
  - o_busy = 0, o_misalign = 0, o_mem_req_wr_en = 0, o_mem_req_count = `MEM_COUNT_NONE.
  - o_result = ALU(0 ADD 0) = 0.
- ALU path: combinational on the registered operands, same latency as today; result valid the cycle after capture.
- MD FSM, states IDLE, RUN, DONE:
  - Any state → RUN on the edge that loads an md_op ≠ NONE; iteration counter = 0; acc/partial registers initialised from operands.
  - Any state → IDLE on a load with md_op = NONE.
  - RUN: each cycle retires BITS_PER_CYCLE bits (shift-add multiply into a 2·WORD_W product; restoring divide). Counter reaches N-1 → DONE with the result latched.
  - DONE: holds the result until the next load.
  - o_busy = (state == RUN), combinational from state.
- MD latency: MD op captured at edge 0; o_busy high for cycles 1..N; o_result valid and o_dest_src released from cycle N+1.
- While o_busy:
  - o_dest_src = `DEST_SRC_NONE.
  - o_mem_req_wr_en = 0, o_mem_req_count = `MEM_COUNT_NONE.
  - This creates a bubble downstream.
- Divide by zero (no trap):
  - DIVU returns all-ones.
  - REMU returns the dividend.
  - Still takes N cycles.
- Memory decode: same mapping as today (WR/RD × WORD/HALF/BYTE → count, wr_en).
- Misalignment:
  - Condition: WORD with addr[1:0] ≠ 0, or HALF with addr[0] ≠ 0.
  - Response: o_misalign = 1, wr_en forced 0, count forced `MEM_COUNT_NONE.
  - BYTE and NOP never misalign.
- Stall in DONE: hold state and result. Stall during RUN: iteration continues; stall only blocks the load.
- clr mid-RUN: FSM → IDLE, counter cleared, o_busy = 0 next cycle, partial result discarded.
- An md_op ≠ NONE combined with mem_op ≠ NOP: md takes priority for o_result; the memory request is still issued after busy drops, using the ALU eval.

Test Plan:
- ADD a=5, b=7, mem NOP → o_result = 12 one cycle after capture; o_busy stays 0.
- MUL a=7, b=6, BITS_PER_CYCLE=1 → o_busy high exactly 32 cycles; then o_result = 42; o_dest_src = `DEST_SRC_NONE only while busy.
- MULHU a=b=0xFFFFFFFF → o_result = 0xFFFFFFFE. DIVU 100/7 → 14; REMU 100/7 → 2. Repeat with BITS_PER_CYCLE=4 → busy 8 cycles, same results.
- DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Word store at addr 0x1002 → o_misalign = 1, wr_en = 0, count NONE. Half read at 0x1002 → no misalign, count HALF, wr_en 0.
- DIVU started, clr asserted on RUN cycle 10 → next cycle o_busy = 0, o_dest_src = `DEST_SRC_NONE, o_result = 0. Separately, stall held high in DONE for 5 cycles → result unchanged.

Source files
------------

// File: rtl/ex_md_if.sv
// Memory-request bus driven by the execute stage toward MEM, plus the shared opcode encodings.
`ifndef EX_MD_DEFS
`define EX_MD_DEFS
`define INSTR_W          32
`define REG_IDX_W        5
`define ALU_OP_W         4
`define ALU_ADD          4'd0
`define ALU_SUB          4'd1
`define ALU_AND          4'd2
`define ALU_OR           4'd3
`define ALU_XOR          4'd4
`define ALU_SLL          4'd5
`define ALU_SRL          4'd6
`define ALU_SRA          4'd7
`define ALU_SLT          4'd8
`define ALU_SLTU         4'd9
`define MEM_OP_W         3
`define MEM_OP_NOP       3'd0
`define MEM_OP_RD_WORD   3'd1
`define MEM_OP_RD_HALF   3'd2
`define MEM_OP_RD_BYTE   3'd3
`define MEM_OP_WR_WORD   3'd5
`define MEM_OP_WR_HALF   3'd6
`define MEM_OP_WR_BYTE   3'd7
`define MEM_COUNT_W      3
`define MEM_COUNT_NONE   3'd0
`define MEM_COUNT_BYTE   3'd1
`define MEM_COUNT_HALF   3'd2
`define MEM_COUNT_WORD   3'd4
`define DEST_SRC_W       2
`define DEST_SRC_NONE    2'd0
`define DEST_SRC_ALU     2'd1
`define DEST_SRC_MEM     2'd2
`define DEST_SRC_PC      2'd3
`endif

interface ex_md_if #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0]       mem_req_addr;
   logic [WORD_W-1:0]       mem_req_wr_data;
   logic                    mem_req_wr_en;
   logic [`MEM_COUNT_W-1:0] mem_req_count;
   logic                    misalign;

   modport master (
      output mem_req_addr, mem_req_wr_data, mem_req_wr_en, mem_req_count, misalign
   );

   modport slave (
      input mem_req_addr, mem_req_wr_data, mem_req_wr_en, mem_req_count, misalign
   );
endinterface

// File: rtl/ex_md.sv
// Execute stage: single-cycle ALU, pipeline register, memory-request decode with alignment
// checking, and an iterative unsigned multiply/divide unit that stalls upstream while busy.
`ifndef EX_MD_DEFS
`define EX_MD_DEFS
`define INSTR_W          32
`define REG_IDX_W        5
`define ALU_OP_W         4
`define ALU_ADD          4'd0
`define ALU_SUB          4'd1
`define ALU_AND          4'd2
`define ALU_OR           4'd3
`define ALU_XOR          4'd4
`define ALU_SLL          4'd5
`define ALU_SRL          4'd6
`define ALU_SRA          4'd7
`define ALU_SLT          4'd8
`define ALU_SLTU         4'd9
`define MEM_OP_W         3
`define MEM_OP_NOP       3'd0
`define MEM_OP_RD_WORD   3'd1
`define MEM_OP_RD_HALF   3'd2
`define MEM_OP_RD_BYTE   3'd3
`define MEM_OP_WR_WORD   3'd5
`define MEM_OP_WR_HALF   3'd6
`define MEM_OP_WR_BYTE   3'd7
`define MEM_COUNT_W      3
`define MEM_COUNT_NONE   3'd0
`define MEM_COUNT_BYTE   3'd1
`define MEM_COUNT_HALF   3'd2
`define MEM_COUNT_WORD   3'd4
`define DEST_SRC_W       2
`define DEST_SRC_NONE    2'd0
`define DEST_SRC_ALU     2'd1
`define DEST_SRC_MEM     2'd2
`define DEST_SRC_PC      2'd3
`endif

module ex_md #(
   parameter int WORD_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   stall,
   input  logic [ADDR_W-1:0]      i_pc,
   input  logic [`INSTR_W-1:0]    i_instr,
   input  logic [`ALU_OP_W-1:0]   i_alu_op,
   input  logic [WORD_W-1:0]      i_alu_data_a,
   input  logic [WORD_W-1:0]      i_alu_data_b,
   input  logic [WORD_W-1:0]      i_imm,
   input  logic [2:0]             i_md_op,
   input  logic [`MEM_OP_W-1:0]   i_mem_op,
   input  logic [`DEST_SRC_W-1:0] i_dest_src,
   input  logic [`REG_IDX_W-1:0]  i_dest_reg,
   output logic [ADDR_W-1:0]      o_pc,
   output logic [`INSTR_W-1:0]    o_instr,
   output logic [`DEST_SRC_W-1:0] o_dest_src,
   output logic [`REG_IDX_W-1:0]  o_dest_reg,
   output logic [WORD_W-1:0]      o_result,
   output logic                   o_busy,
   ex_md_if.master                mem
);
   localparam int N     = WORD_W / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int SH_W  = $clog2(WORD_W);

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MUL   = 3'd1;
   localparam logic [2:0] MD_MULHU = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_REMU  = 3'd4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_next;

   logic [ADDR_W-1:0]       pc_q;
   logic [`INSTR_W-1:0]     instr_q;
   logic [`ALU_OP_W-1:0]    alu_op_q;
   logic [WORD_W-1:0]       a_q, b_q, imm_q;
   logic [2:0]              md_op_q;
   logic [`MEM_OP_W-1:0]    mem_op_q;
   logic [`DEST_SRC_W-1:0]  dest_src_q;
   logic [`REG_IDX_W-1:0]   dest_reg_q;

   logic                    load, md_start, in_is_mul, step_en, last_iter, is_mul_q;
   logic [CNT_W-1:0]        cnt;
   logic [WORD_W-1:0]       acc_hi, acc_lo, operand;
   logic [WORD_W-1:0]       hi_step, lo_step;
   logic [WORD_W:0]         sum, rem_sh;
   logic [WORD_W-1:0]       alu_eval, md_res;
   logic [`MEM_COUNT_W-1:0] raw_count, req_count;
   logic                    raw_wr_en, req_wr_en, misalign;

   assign load      = !stall && !o_busy;
   assign md_start  = (i_md_op >= MD_MUL) && (i_md_op <= MD_REMU);
   assign in_is_mul = (i_md_op == MD_MUL) || (i_md_op == MD_MULHU);
   assign is_mul_q  = (md_op_q == MD_MUL) || (md_op_q == MD_MULHU);
   assign last_iter = (cnt == CNT_W'(N - 1));

   // Unknown md codes are folded to NONE at capture so everything downstream sees five values only.
   always_ff @(posedge clk) begin
      if (clr) begin
         pc_q       <= '0;
         instr_q    <= '0;
         alu_op_q   <= `ALU_ADD;
         a_q        <= '0;
         b_q        <= '0;
         imm_q      <= '0;
         md_op_q    <= MD_NONE;
         mem_op_q   <= `MEM_OP_NOP;
         dest_src_q <= `DEST_SRC_NONE;
         dest_reg_q <= '0;
      end else if (load) begin
         pc_q       <= i_pc;
         instr_q    <= i_instr;
         alu_op_q   <= i_alu_op;
         a_q        <= i_alu_data_a;
         b_q        <= i_alu_data_b;
         imm_q      <= i_imm;
         md_op_q    <= md_start ? i_md_op : MD_NONE;
         mem_op_q   <= i_mem_op;
         dest_src_q <= i_dest_src;
         dest_reg_q <= i_dest_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (load)
         state_next = md_start ? RUN : IDLE;
      else if (state == RUN && last_iter)
         state_next = DONE;
   end

   always_comb begin
      o_busy  = 1'b0;
      step_en = 1'b0;
      if (state == RUN) begin
         o_busy  = 1'b1;
         step_en = 1'b1;
      end
   end

   // acc_hi:acc_lo is the product for multiplies and remainder:quotient for divides.
   always_comb begin
      hi_step = acc_hi;
      lo_step = acc_lo;
      sum     = '0;
      rem_sh  = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (is_mul_q) begin
            sum     = {1'b0, hi_step} + ({1'b0, operand} & {(WORD_W+1){lo_step[0]}});
            lo_step = {sum[0], lo_step[WORD_W-1:1]};
            hi_step = sum[WORD_W:1];
         end else begin
            rem_sh = {hi_step, lo_step[WORD_W-1]};
            if (rem_sh >= {1'b0, operand}) begin
               hi_step = rem_sh[WORD_W-1:0] - operand;
               lo_step = {lo_step[WORD_W-2:0], 1'b1};
            end else begin
               hi_step = rem_sh[WORD_W-1:0];
               lo_step = {lo_step[WORD_W-2:0], 1'b0};
            end
         end
      end
   end

   // A zero divisor always subtracts, so the quotient fills with ones and the remainder ends as the dividend.
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         operand <= '0;
      end else if (load) begin
         cnt    <= '0;
         acc_hi <= '0;
         if (in_is_mul) begin
            acc_lo  <= i_alu_data_b;
            operand <= i_alu_data_a;
         end else begin
            acc_lo  <= i_alu_data_a;
            operand <= i_alu_data_b;
         end
      end else if (step_en) begin
         acc_hi <= hi_step;
         acc_lo <= lo_step;
         cnt    <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      alu_eval = '0;
      case (alu_op_q)
         `ALU_ADD:  alu_eval = a_q + b_q;
         `ALU_SUB:  alu_eval = a_q - b_q;
         `ALU_AND:  alu_eval = a_q & b_q;
         `ALU_OR:   alu_eval = a_q | b_q;
         `ALU_XOR:  alu_eval = a_q ^ b_q;
         `ALU_SLL:  alu_eval = a_q << b_q[SH_W-1:0];
         `ALU_SRL:  alu_eval = a_q >> b_q[SH_W-1:0];
         `ALU_SRA:  alu_eval = WORD_W'($signed(a_q) >>> b_q[SH_W-1:0]);
         `ALU_SLT:  alu_eval = {{(WORD_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
         `ALU_SLTU: alu_eval = {{(WORD_W-1){1'b0}}, a_q < b_q};
         default:   alu_eval = a_q + b_q;
      endcase
   end

   always_comb begin
      md_res = acc_lo;
      if (md_op_q == MD_MULHU || md_op_q == MD_REMU)
         md_res = acc_hi;
   end

   // No request (and so no misalignment) is presented while the MD unit holds the pipe.
   always_comb begin
      raw_count = `MEM_COUNT_NONE;
      raw_wr_en = 1'b0;
      case (mem_op_q)
         `MEM_OP_RD_WORD: raw_count = `MEM_COUNT_WORD;
         `MEM_OP_RD_HALF: raw_count = `MEM_COUNT_HALF;
         `MEM_OP_RD_BYTE: raw_count = `MEM_COUNT_BYTE;
         `MEM_OP_WR_WORD: begin raw_count = `MEM_COUNT_WORD; raw_wr_en = 1'b1; end
         `MEM_OP_WR_HALF: begin raw_count = `MEM_COUNT_HALF; raw_wr_en = 1'b1; end
         `MEM_OP_WR_BYTE: begin raw_count = `MEM_COUNT_BYTE; raw_wr_en = 1'b1; end
         default:         raw_count = `MEM_COUNT_NONE;
      endcase
      misalign  = ((raw_count == `MEM_COUNT_WORD) && (alu_eval[1:0] != 2'b00)) ||
                  ((raw_count == `MEM_COUNT_HALF) && alu_eval[0]);
      req_count = raw_count;
      req_wr_en = raw_wr_en;
      if (o_busy || misalign) begin
         req_count = `MEM_COUNT_NONE;
         req_wr_en = 1'b0;
      end
      if (o_busy)
         misalign = 1'b0;
   end

   assign o_pc                = pc_q;
   assign o_instr             = instr_q;
   assign o_dest_reg          = dest_reg_q;
   assign o_dest_src          = o_busy ? `DEST_SRC_NONE : dest_src_q;
   assign o_result            = (md_op_q != MD_NONE) ? md_res : alu_eval;
   assign mem.mem_req_addr    = alu_eval[ADDR_W-1:0];
   assign mem.mem_req_wr_data = imm_q;
   assign mem.mem_req_wr_en   = req_wr_en;
   assign mem.mem_req_count   = req_count;
   assign mem.misalign        = misalign;
endmodule

// File: tb/tb_ex_md.sv
// Randomised bench for ex_md: two instances (1 and 4 bits per cycle) share stimulus and are
// compared against arithmetic reference models for the ALU, MD unit and memory decode.
`ifndef EX_MD_DEFS
`define EX_MD_DEFS
`define INSTR_W          32
`define REG_IDX_W        5
`define ALU_OP_W         4
`define ALU_ADD          4'd0
`define ALU_SUB          4'd1
`define ALU_AND          4'd2
`define ALU_OR           4'd3
`define ALU_XOR          4'd4
`define ALU_SLL          4'd5
`define ALU_SRL          4'd6
`define ALU_SRA          4'd7
`define ALU_SLT          4'd8
`define ALU_SLTU         4'd9
`define MEM_OP_W         3
`define MEM_OP_NOP       3'd0
`define MEM_OP_RD_WORD   3'd1
`define MEM_OP_RD_HALF   3'd2
`define MEM_OP_RD_BYTE   3'd3
`define MEM_OP_WR_WORD   3'd5
`define MEM_OP_WR_HALF   3'd6
`define MEM_OP_WR_BYTE   3'd7
`define MEM_COUNT_W      3
`define MEM_COUNT_NONE   3'd0
`define MEM_COUNT_BYTE   3'd1
`define MEM_COUNT_HALF   3'd2
`define MEM_COUNT_WORD   3'd4
`define DEST_SRC_W       2
`define DEST_SRC_NONE    2'd0
`define DEST_SRC_ALU     2'd1
`define DEST_SRC_MEM     2'd2
`define DEST_SRC_PC      2'd3
`endif

module tb_ex_md;
   logic                   clk = 1'b0;
   logic                   clr, stall;
   logic [31:0]            pc;
   logic [`INSTR_W-1:0]    instr;
   logic [`ALU_OP_W-1:0]   alu_op;
   logic [31:0]            a, b, imm;
   logic [2:0]             md_op;
   logic [`MEM_OP_W-1:0]   mem_op;
   logic [`DEST_SRC_W-1:0] dest_src;
   logic [`REG_IDX_W-1:0]  dest_reg;

   logic [31:0]            pc1, pc4, res1, res4;
   logic [`INSTR_W-1:0]    instr1, instr4;
   logic [`DEST_SRC_W-1:0] dsrc1, dsrc4;
   logic [`REG_IDX_W-1:0]  dreg1, dreg4;
   logic                   busy1, busy4;

   int total = 0;
   int bad   = 0;

   ex_md_if #(.WORD_W(32), .ADDR_W(32)) mem1 ();
   ex_md_if #(.WORD_W(32), .ADDR_W(32)) mem4 ();

   ex_md #(.WORD_W(32), .ADDR_W(32), .BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .clr(clr), .stall(stall), .i_pc(pc), .i_instr(instr), .i_alu_op(alu_op),
      .i_alu_data_a(a), .i_alu_data_b(b), .i_imm(imm), .i_md_op(md_op), .i_mem_op(mem_op),
      .i_dest_src(dest_src), .i_dest_reg(dest_reg), .o_pc(pc1), .o_instr(instr1),
      .o_dest_src(dsrc1), .o_dest_reg(dreg1), .o_result(res1), .o_busy(busy1), .mem(mem1.master)
   );

   ex_md #(.WORD_W(32), .ADDR_W(32), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .clr(clr), .stall(stall), .i_pc(pc), .i_instr(instr), .i_alu_op(alu_op),
      .i_alu_data_a(a), .i_alu_data_b(b), .i_imm(imm), .i_md_op(md_op), .i_mem_op(mem_op),
      .i_dest_src(dest_src), .i_dest_reg(dest_reg), .o_pc(pc4), .o_instr(instr4),
      .o_dest_src(dsrc4), .o_dest_reg(dreg4), .o_result(res4), .o_busy(busy4), .mem(mem4.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      case (op)
         `ALU_SUB:  return x - y;
         `ALU_AND:  return x & y;
         `ALU_OR:   return x | y;
         `ALU_XOR:  return x ^ y;
         `ALU_SLL:  return x << (y % 32);
         `ALU_SRL:  return x >> (y % 32);
         `ALU_SRA:  return 32'($signed(x) >>> (y % 32));
         `ALU_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         `ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
         default:   return x + y;
      endcase
   endfunction

   function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      p = 64'(x) * 64'(y);
      case (op)
         3'd1:    return p[31:0];
         3'd2:    return p[63:32];
         3'd3:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd4:    return (y == 0) ? x : x % y;
         default: return 32'd0;
      endcase
   endfunction

   // Returns {misalign, wr_en, count} from access size in bytes and address modulo that size.
   function automatic logic [4:0] mem_model(input logic [2:0] op, input logic [31:0] addr);
      int  size;
      logic wr;
      size = 0;
      wr   = 1'b0;
      case (op)
         `MEM_OP_RD_WORD: size = 4;
         `MEM_OP_RD_HALF: size = 2;
         `MEM_OP_RD_BYTE: size = 1;
         `MEM_OP_WR_WORD: begin size = 4; wr = 1'b1; end
         `MEM_OP_WR_HALF: begin size = 2; wr = 1'b1; end
         `MEM_OP_WR_BYTE: begin size = 1; wr = 1'b1; end
         default:         size = 0;
      endcase
      if (size > 1 && (addr % size) != 0) return {1'b1, 1'b0, 3'd0};
      return {1'b0, wr && size != 0, 3'(size)};
   endfunction

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [2:0] mop, input logic [2:0] mem, input logic [31:0] im);
      @(negedge clk);
      alu_op   = op;
      a        = x;
      b        = y;
      md_op    = mop;
      mem_op   = mem;
      imm      = im;
      dest_src = `DEST_SRC_ALU;
      dest_reg = 5'($urandom_range(1, 31));
      pc       = $urandom;
      instr    = $urandom;
   endtask

   task automatic test_reset();
      applyStimulus(`ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 3'd2, `MEM_OP_WR_WORD, 32'hDEAD);
      clr   = 1'b1;
      stall = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (busy1 !== 1'b0 || busy4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got %b/%b want 0", busy1, busy4); end
      total++;
      if (res1 !== 32'd0 || res4 !== 32'd0) begin bad++; $display("[TB] FAIL reset_result got %h/%h want 0", res1, res4); end
      total++;
      if (mem1.misalign !== 1'b0 || mem1.mem_req_wr_en !== 1'b0 || mem1.mem_req_count !== `MEM_COUNT_NONE ||
          mem4.misalign !== 1'b0 || mem4.mem_req_wr_en !== 1'b0 || mem4.mem_req_count !== `MEM_COUNT_NONE) begin
         bad++;
         $display("[TB] FAIL reset_mem got mis=%b wr=%b cnt=%0d want 0 0 0", mem1.misalign, mem1.mem_req_wr_en, mem1.mem_req_count);
      end
      total++;
      if (dsrc1 !== `DEST_SRC_NONE || dsrc4 !== `DEST_SRC_NONE || pc1 !== 32'd0 || dreg1 !== 5'd0) begin
         bad++;
         $display("[TB] FAIL reset_regs got dsrc=%0d pc=%h dreg=%0d want 0 0 0", dsrc1, pc1, dreg1);
      end
      applyStimulus(`ALU_ADD, 0, 0, 3'd0, `MEM_OP_NOP, 0);
      clr = 1'b0;
   endtask

   task automatic test_alu();
      logic [31:0] exp, epc, einstr;
      logic [4:0]  ereg;
      for (int i = 0; i < 24; i++) begin
         if (i == 0) applyStimulus(`ALU_ADD, 32'd5, 32'd7, 3'd0, `MEM_OP_NOP, 0);
         else        applyStimulus(4'($urandom_range(0, 9)), $urandom, (i % 3 == 0) ? $urandom_range(0, 40) : $urandom,
                                   (i % 5 == 0) ? 3'($urandom_range(5, 7)) : 3'd0, `MEM_OP_NOP, 0);
         exp    = alu_model(alu_op, a, b);
         epc    = pc;
         einstr = instr;
         ereg   = dest_reg;
         @(negedge clk);
         total++;
         if (res1 !== exp || res4 !== exp || busy1 !== 1'b0 || busy4 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alu_%0d op=%0d got %h/%h busy=%b want %h busy=0", i, alu_op, res1, res4, busy1, exp);
         end
         total++;
         if (pc1 !== epc || instr1 !== einstr || dreg1 !== ereg || dsrc1 !== `DEST_SRC_ALU ||
             pc4 !== epc || instr4 !== einstr || dreg4 !== ereg || dsrc4 !== `DEST_SRC_ALU) begin
            bad++;
            $display("[TB] FAIL pipe_%0d got pc=%h instr=%h reg=%0d want %h %h %0d", i, pc1, instr1, dreg1, epc, einstr, ereg);
         end
      end
   endtask

   task automatic test_mem();
      logic [31:0] addr;
      logic [4:0]  exp;
      for (int i = 0; i < 16; i++) begin
         case (i)
            0:       applyStimulus(`ALU_ADD, 32'h1000, 32'd2, 3'd0, `MEM_OP_WR_WORD, 32'hCAFE);
            1:       applyStimulus(`ALU_ADD, 32'h1000, 32'd2, 3'd0, `MEM_OP_RD_HALF, 32'hBEEF);
            2:       applyStimulus(`ALU_ADD, 32'h1000, 32'd3, 3'd0, `MEM_OP_WR_BYTE, 32'h55);
            3:       applyStimulus(`ALU_ADD, 32'h1000, 32'd1, 3'd0, `MEM_OP_WR_HALF, 32'h66);
            default: applyStimulus(`ALU_ADD, $urandom & 32'hFFFF_FFF8, $urandom_range(0, 7), 3'd0,
                                   3'($urandom_range(0, 7)), $urandom);
         endcase
         addr = a + b;
         exp  = mem_model(mem_op, addr);
         @(negedge clk);
         total++;
         if (mem1.misalign !== exp[4] || mem1.mem_req_wr_en !== exp[3] || mem1.mem_req_count !== exp[2:0] ||
             mem4.misalign !== exp[4] || mem4.mem_req_wr_en !== exp[3] || mem4.mem_req_count !== exp[2:0]) begin
            bad++;
            $display("[TB] FAIL mem_%0d op=%0d addr=%h got mis=%b wr=%b cnt=%0d want %b %b %0d", i, mem_op, addr,
                     mem1.misalign, mem1.mem_req_wr_en, mem1.mem_req_count, exp[4], exp[3], exp[2:0]);
         end
         total++;
         if (mem1.mem_req_addr !== addr || mem1.mem_req_wr_data !== imm ||
             mem4.mem_req_addr !== addr || mem4.mem_req_wr_data !== imm) begin
            bad++;
            $display("[TB] FAIL mem_bus_%0d got addr=%h data=%h want %h %h", i, mem1.mem_req_addr, mem1.mem_req_wr_data, addr, imm);
         end
      end
   endtask

   // Issues an MD op, then stalls so each instance parks in DONE; checks latency, result and bubble.
   task automatic test_md_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                             input logic [2:0] mem, input logic [31:0] im);
      logic [31:0] exp, addr;
      logic [4:0]  mexp;
      int n1, n4, ds_bad, req_bad;
      applyStimulus(`ALU_ADD, x, y, op, mem, im);
      stall = 1'b0;
      exp   = md_model(op, x, y);
      addr  = x + y;
      mexp  = mem_model(mem, addr);
      @(negedge clk);
      stall   = 1'b1;
      md_op   = 3'd0;
      n1      = 0;
      n4      = 0;
      ds_bad  = 0;
      req_bad = 0;
      for (int c = 0; c < 64; c++) begin
         if (busy1) n1++;
         if (busy4) n4++;
         if ((busy1 && dsrc1 !== `DEST_SRC_NONE) || (busy4 && dsrc4 !== `DEST_SRC_NONE)) ds_bad++;
         if ((busy1 && (mem1.mem_req_wr_en !== 1'b0 || mem1.mem_req_count !== `MEM_COUNT_NONE)) ||
             (busy4 && (mem4.mem_req_wr_en !== 1'b0 || mem4.mem_req_count !== `MEM_COUNT_NONE))) req_bad++;
         if (!busy1 && !busy4) break;
         @(negedge clk);
      end
      total++;
      if (n1 !== 32 || n4 !== 8) begin bad++; $display("[TB] FAIL md_busy op=%0d got %0d/%0d cycles want 32/8", op, n1, n4); end
      total++;
      if (res1 !== exp || res4 !== exp) begin
         bad++;
         $display("[TB] FAIL md_result op=%0d a=%h b=%h got %h/%h want %h", op, x, y, res1, res4, exp);
      end
      total++;
      if (ds_bad != 0 || dsrc1 !== `DEST_SRC_ALU || dsrc4 !== `DEST_SRC_ALU) begin
         bad++;
         $display("[TB] FAIL md_dest_src got %0d/%0d with %0d busy leaks want %0d", dsrc1, dsrc4, ds_bad, `DEST_SRC_ALU);
      end
      total++;
      if (req_bad != 0 || mem1.misalign !== mexp[4] || mem1.mem_req_wr_en !== mexp[3] || mem1.mem_req_count !== mexp[2:0]) begin
         bad++;
         $display("[TB] FAIL md_mem got mis=%b wr=%b cnt=%0d leaks=%0d want %b %b %0d", mem1.misalign,
                  mem1.mem_req_wr_en, mem1.mem_req_count, req_bad, mexp[4], mexp[3], mexp[2:0]);
      end
      mem_op = `MEM_OP_NOP;
      stall  = 1'b0;
   endtask

   task automatic test_md_directed();
      test_md_op(3'd1, 32'd7, 32'd6, `MEM_OP_NOP, 0);
      test_md_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, `MEM_OP_NOP, 0);
      test_md_op(3'd3, 32'd100, 32'd7, `MEM_OP_NOP, 0);
      test_md_op(3'd4, 32'd100, 32'd7, `MEM_OP_NOP, 0);
      test_md_op(3'd3, 32'd9, 32'd0, `MEM_OP_NOP, 0);
      test_md_op(3'd4, 32'd9, 32'd0, `MEM_OP_NOP, 0);
      test_md_op(3'd1, 32'd8, 32'd4, `MEM_OP_WR_WORD, 32'hCAFE);
      test_md_op(3'd1, 32'd7, 32'd6, `MEM_OP_WR_WORD, 32'hCAFE);
   endtask

   task automatic test_md_random();
      for (int i = 0; i < 6; i++)
         test_md_op(3'($urandom_range(1, 4)), $urandom, (i == 2) ? 32'd0 : $urandom >> $urandom_range(0, 28),
                    `MEM_OP_NOP, 0);
   endtask

   task automatic test_stall_done();
      logic [31:0] exp, nxt;
      int wait_cnt;
      applyStimulus(`ALU_ADD, 32'hDEAD_BEEF, 32'h0001_2345, 3'd3, `MEM_OP_NOP, 0);
      exp = md_model(3'd3, a, b);
      @(negedge clk);
      stall = 1'b1;
      md_op = 3'd0;
      a     = 32'd40;
      b     = 32'd2;
      nxt   = 32'd42;
      wait_cnt = 0;
      while (busy1 && wait_cnt < 64) begin @(negedge clk); wait_cnt++; end
      total++;
      if (busy1 !== 1'b0) begin bad++; $display("[TB] FAIL stall_timeout busy still %b", busy1); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (res1 !== exp || res4 !== exp || busy1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_hold_%0d got %h/%h busy=%b want %h", i, res1, res4, busy1, exp);
         end
      end
      stall = 1'b0;
      @(negedge clk);
      total++;
      if (res1 !== nxt || res4 !== nxt) begin bad++; $display("[TB] FAIL stall_release got %h/%h want %h", res1, res4, nxt); end
   endtask

   task automatic test_clr_mid_run();
      applyStimulus(`ALU_ADD, 32'd1000, 32'd3, 3'd3, `MEM_OP_NOP, 0);
      @(negedge clk);
      md_op = 3'd0;
      stall = 1'b1;
      repeat (9) @(negedge clk);
      total++;
      if (busy1 !== 1'b1) begin bad++; $display("[TB] FAIL clr_pre_busy got %b want 1", busy1); end
      clr = 1'b1;
      @(negedge clk);
      total++;
      if (busy1 !== 1'b0 || busy4 !== 1'b0 || dsrc1 !== `DEST_SRC_NONE || dsrc4 !== `DEST_SRC_NONE ||
          res1 !== 32'd0 || res4 !== 32'd0) begin
         bad++;
         $display("[TB] FAIL clr_mid_run got busy=%b dsrc=%0d res=%h/%h want 0 0 0", busy1, dsrc1, res1, res4);
      end
      clr   = 1'b0;
      stall = 1'b0;
      applyStimulus(`ALU_ADD, 0, 0, 3'd0, `MEM_OP_NOP, 0);
   endtask

   initial begin
      clr = 1'b1; stall = 1'b0; pc = 0; instr = 0; alu_op = `ALU_ADD; a = 0; b = 0; imm = 0;
      md_op = 0; mem_op = `MEM_OP_NOP; dest_src = `DEST_SRC_NONE; dest_reg = 0;
      test_reset();
      test_alu();
      test_mem();
      test_md_directed();
      test_md_random();
      test_stall_done();
      test_clr_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
